atm_controller_param: RTL and testbench

Parametrised next-generation ATM session controller: card detection, BCD PIN entry with configurable length and attempt limit, deposit/withdrawal with per-transaction withdrawal limit, saturating balance arithmetic, inactivity timeout and sticky lockout. It sits between the keypad/card-reader front end and the cash dispenser/account interface. All status outputs are registered.

---
 rtl/atm_controller_param.sv | 223 ++++++++++++++++++++++
 tb/tb_atm_controller_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_controller_param.sv
// ATM session controller: card detect, BCD PIN entry with attempt limit,
// deposit / withdrawal with per-transaction limit, saturating balance,
// inactivity timeout and sticky lockout. All outputs are registered.
module atm_controller_param #(
  parameter int unsigned                 PIN_DIGITS      = 4,
  parameter logic [4*PIN_DIGITS-1:0]     PIN_CORRECTO    = (4*PIN_DIGITS)'('h4756),
  parameter int unsigned                 MAX_INTENTOS    = 3,
  parameter int unsigned                 AMT_W           = 32,
  parameter int unsigned                 BAL_W           = 64,
  parameter logic [BAL_W-1:0]            BALANCE_INICIAL = BAL_W'(4500),
  parameter logic [AMT_W-1:0]            LIMITE_RETIRO   = AMT_W'(2000),
  parameter int unsigned                 TIMEOUT_CICLOS  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tarjeta_recibida,
  input  logic             tipo_trans,
  input  logic             digito_stb,
  input  logic [3:0]       digito,
  input  logic             monto_stb,
  input  logic [AMT_W-1:0] monto,
  output logic             balance_actualizado,
  output logic             entregar_dinero,
  output logic             pin_incorrecto,
  output logic             advertencia,
  output logic             bloqueo,
  output logic             fondos_insuficientes,
  output logic             limite_excedido,
  output logic             timeout,
  output logic [BAL_W-1:0] balance
);

  localparam int unsigned PW = 4 * PIN_DIGITS;
  localparam int unsigned CW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned IW = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS);

  typedef enum logic [2:0] {
    ESPERANDO_TARJETA,
    INGRESO_PIN,
    DEPOSITO,
    RETIRO,
    BLOQUEO
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [PW-1:0]    pin_q, pin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    intento_q, intento_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             bal_act_q, bal_act_d;
  logic             entregar_q, entregar_d;
  logic             pin_inc_q, pin_inc_d;
  logic             adv_q, adv_d;
  logic             bloq_q, bloq_d;
  logic             fondos_q, fondos_d;
  logic             limite_q, limite_d;
  logic             to_q, to_d;

  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;
  logic [IW-1:0]    intento_inc;
  logic             expira;

  // Next-state, datapath and output-pulse computation
  always_comb begin
    estado_d   = estado_q;
    pin_d      = pin_q;
    cnt_d      = cnt_q;
    intento_d  = intento_q;
    timer_d    = timer_q;
    balance_d  = balance_q;
    adv_d      = adv_q;
    bloq_d     = bloq_q;
    bal_act_d  = 1'b0;
    entregar_d = 1'b0;
    pin_inc_d  = 1'b0;
    fondos_d   = 1'b0;
    limite_d   = 1'b0;
    to_d       = 1'b0;

    monto_ext   = BAL_W'(monto);
    suma        = {1'b0, balance_q} + {1'b0, monto_ext};
    intento_inc = intento_q + 1'b1;
    expira      = (timer_q == TW'(TIMEOUT_CICLOS - 1));

    unique case (estado_q)
      ESPERANDO_TARJETA: begin
        if (tarjeta_recibida) begin
          estado_d = INGRESO_PIN;
          cnt_d    = '0;
          pin_d    = '0;
          timer_d  = '0;
        end
      end

      INGRESO_PIN: begin
        // Compare cycle takes priority over keypad and idle timer; the timer
        // restarts for the next attempt or for the transaction phase.
        if (cnt_q == CW'(PIN_DIGITS)) begin
          cnt_d   = '0;
          pin_d   = '0;
          timer_d = '0;
          if (pin_q == PIN_CORRECTO) begin
            intento_d = '0;
            adv_d     = 1'b0;
            estado_d  = tipo_trans ? RETIRO : DEPOSITO;
          end else begin
            intento_d = intento_inc;
            pin_inc_d = 1'b1;
            if (intento_inc == IW'(MAX_INTENTOS)) begin
              estado_d = BLOQUEO;
              bloq_d   = 1'b1;
              adv_d    = 1'b0;
            end else if (intento_inc == IW'(MAX_INTENTOS - 1)) begin
              adv_d = 1'b1;
            end
          end
        end else if (digito_stb) begin
          timer_d = '0;
          if (digito <= 4'd9) begin
            pin_d = (pin_q << 4) | PW'(digito);
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expira) begin
          to_d     = 1'b1;
          timer_d  = '0;
          estado_d = ESPERANDO_TARJETA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DEPOSITO: begin
        if (monto_stb) begin
          balance_d = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
          bal_act_d = 1'b1;
          estado_d  = ESPERANDO_TARJETA;
        end else if (expira) begin
          to_d     = 1'b1;
          timer_d  = '0;
          estado_d = ESPERANDO_TARJETA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RETIRO: begin
        if (monto_stb) begin
          estado_d = ESPERANDO_TARJETA;
          if (monto > LIMITE_RETIRO) begin
            limite_d = 1'b1;
          end else if (monto_ext > balance_q) begin
            fondos_d = 1'b1;
          end else begin
            balance_d  = balance_q - monto_ext;
            entregar_d = 1'b1;
            bal_act_d  = 1'b1;
          end
        end else if (expira) begin
          to_d     = 1'b1;
          timer_d  = '0;
          estado_d = ESPERANDO_TARJETA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      BLOQUEO: begin
        bloq_d = 1'b1;
      end

      default: estado_d = ESPERANDO_TARJETA;
    endcase
  end

  // State and registered outputs; reset overrides every input
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= ESPERANDO_TARJETA;
      pin_q      <= '0;
      cnt_q      <= '0;
      intento_q  <= '0;
      timer_q    <= '0;
      balance_q  <= BALANCE_INICIAL;
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      fondos_q   <= 1'b0;
      limite_q   <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pin_q      <= pin_d;
      cnt_q      <= cnt_d;
      intento_q  <= intento_d;
      timer_q    <= timer_d;
      balance_q  <= balance_d;
      bal_act_q  <= bal_act_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      fondos_q   <= fondos_d;
      limite_q   <= limite_d;
      to_q       <= to_d;
    end
  end

  assign balance_actualizado  = bal_act_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloq_q;
  assign fondos_insuficientes = fondos_q;
  assign limite_excedido      = limite_q;
  assign timeout              = to_q;
  assign balance              = balance_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// Bench for atm_controller_param: table-driven transaction vectors plus
// hand-written sequences for lockout, attempt clearing, timeout and saturation.
module tb_atm_controller_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_trans = 1'b0;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = '0;
  logic        monto_stb = 1'b0;
  logic [31:0] monto = '0;

  logic        bal_act, entregar, pin_inc, adv, bloq, fondos, limite, to;
  logic [63:0] balance;
  logic        bal_act16, entregar16, pin_inc16, adv16, bloq16, fondos16, limite16, to16;
  logic [15:0] balance16;

  always #5 clk = ~clk;

  atm_controller_param dut (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto),
    .balance_actualizado(bal_act), .entregar_dinero(entregar), .pin_incorrecto(pin_inc),
    .advertencia(adv), .bloqueo(bloq), .fondos_insuficientes(fondos),
    .limite_excedido(limite), .timeout(to), .balance(balance)
  );

  atm_controller_param #(
    .AMT_W(16), .BAL_W(16), .BALANCE_INICIAL(16'd65000), .LIMITE_RETIRO(16'd2000)
  ) dut16 (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto[15:0]),
    .balance_actualizado(bal_act16), .entregar_dinero(entregar16), .pin_incorrecto(pin_inc16),
    .advertencia(adv16), .bloqueo(bloq16), .fondos_insuficientes(fondos16),
    .limite_excedido(limite16), .timeout(to16), .balance(balance16)
  );

  // Output vector order: {bal_act, entregar, pin_inc, adv, bloq, fondos, limite, timeout}
  localparam logic [7:0] BA = 8'b1000_0000, EN = 8'b0100_0000, PI = 8'b0010_0000,
                         AD = 8'b0001_0000, BL = 8'b0000_1000, FO = 8'b0000_0100,
                         LI = 8'b0000_0010, TO = 8'b0000_0001;
  localparam logic [7:0] M_ALL = 8'hFF, M_NOADV = 8'hEF;

  logic [7:0] outv, outv16;
  assign outv   = {bal_act, entregar, pin_inc, adv, bloq, fondos, limite, to};
  assign outv16 = {bal_act16, entregar16, pin_inc16, adv16, bloq16, fondos16, limite16, to16};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        r, c, t, ds;
    logic [3:0]  d;
    logic        ms;
    logic [31:0] m;
    logic [7:0]  e;
    logic [63:0] b;
  } vec_t;
  vec_t tbl[$];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp,
                      input logic [7:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b (mask %b)", nm, act, exp, mask);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive on falling edge, sample 1ns after the rising edge
  task automatic cyc(input logic r, input logic c, input logic t, input logic ds,
                     input logic [3:0] d, input logic ms, input logic [31:0] m);
    @(negedge clk);
    rst = r; tarjeta_recibida = c; tipo_trans = t;
    digito_stb = ds; digito = d; monto_stb = ms; monto = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic t);
    cyc(0, 0, t, 0, 4'd0, 0, 32'd0);
  endtask

  task automatic pin(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, v[15:12], 0, 32'd0);
      v = v << 4;
    end
  endtask

  function automatic void push(input logic r, input logic c, input logic t, input logic ds,
                               input logic [3:0] d, input logic ms, input logic [31:0] m,
                               input logic [7:0] e, input logic [63:0] b);
    vec_t v;
    v.r = r; v.c = c; v.t = t; v.ds = ds; v.d = d; v.ms = ms; v.m = m; v.e = e; v.b = b;
    tbl.push_back(v);
  endfunction

  // Card, PIN 4-7-5-6, compare cycle, amount strobe, one idle cycle
  function automatic void add_session(input logic t, input logic [31:0] m, input logic [7:0] pe,
                                      input logic [63:0] b0, input logic [63:0] b1);
    push(0, 1, 0, 0, 4'd0, 0, 0, 8'h00, b0);
    push(0, 0, 0, 1, 4'd4, 0, 0, 8'h00, b0);
    push(0, 0, 0, 1, 4'd7, 0, 0, 8'h00, b0);
    push(0, 0, 0, 1, 4'd5, 0, 0, 8'h00, b0);
    push(0, 0, 0, 1, 4'd6, 0, 0, 8'h00, b0);
    push(0, 0, t, 0, 4'd0, 0, 0, 8'h00, b0);
    push(0, 0, 0, 0, 4'd0, 1, m, pe,    b1);
    push(0, 0, 0, 0, 4'd0, 0, 0, 8'h00, b1);
  endfunction

  initial begin
    int n;
    int tos;

    push(1, 0, 0, 0, 4'd0, 0, 0, 8'h00, 64'd4500);
    add_session(0, 32'd500,  BA,      64'd4500, 64'd5000);
    push(1, 0, 0, 0, 4'd0, 0, 0, 8'h00, 64'd4500);
    add_session(1, 32'd4501, LI,      64'd4500, 64'd4500);
    add_session(1, 32'd2001, LI,      64'd4500, 64'd4500);
    add_session(1, 32'd2000, BA | EN, 64'd4500, 64'd2500);
    add_session(1, 32'd2000, BA | EN, 64'd2500, 64'd500);
    add_session(1, 32'd501,  FO,      64'd500,  64'd500);
    add_session(1, 32'd500,  BA | EN, 64'd500,  64'd0);
    add_session(0, 32'd0,    BA,      64'd0,    64'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].t, tbl[i].ds, tbl[i].d, tbl[i].ms, tbl[i].m);
      chk8($sformatf("vec%0d_out", i), outv, tbl[i].e, M_ALL);
      chk64($sformatf("vec%0d_balance", i), balance, tbl[i].b);
    end

    // Three wrong PINs across a card re-insertion lead to sticky lockout
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    chk8("lock_reset", outv, 8'h00, M_ALL);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h1111);
    idle(0); chk8("lock_wrong1", outv, PI, M_ALL);
    idle(0); chk8("lock_wrong1_deassert", outv, 8'h00, M_ALL);
    pin(16'h1111);
    idle(0); chk8("lock_wrong2", outv, PI | AD, M_ALL);
    idle(0); chk8("lock_adv_level", outv, AD, M_ALL);
    cyc(0, 0, 0, 0, 4'd0, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk8("lock_reinsert", outv, AD, M_ALL);
    pin(16'h1111);
    idle(0); chk8("lock_wrong3", outv, PI | BL, M_NOADV);
    idle(0); chk8("lock_sticky", outv, BL, M_NOADV);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h4756);
    idle(0);
    cyc(0, 0, 0, 0, 4'd0, 1, 32'd100);
    chk8("lock_ignores_inputs", outv, BL, M_NOADV);
    chk64("lock_balance", balance, 64'd4500);
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    chk8("lock_rst_clear", outv, 8'h00, M_ALL);
    chk64("lock_rst_balance", balance, 64'd4500);

    // Two wrong PINs then the correct one clears the attempt count
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h1111); idle(0);
    pin(16'h1111); idle(0);
    chk8("clr_adv_set", outv, PI | AD, M_ALL);
    pin(16'h4756);
    idle(0); chk8("clr_match", outv, 8'h00, M_ALL);
    cyc(0, 0, 0, 0, 4'd0, 1, 32'd100);
    chk8("clr_deposit", outv, BA, M_ALL);
    chk64("clr_balance", balance, 64'd4600);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h2222);
    idle(0); chk8("clr_intento_zero", outv, PI, M_ALL);
    pin(16'h2222);
    idle(0); chk8("clr_second_warn", outv, PI | AD, M_ALL);

    // Inactivity timeout mid-PIN; an invalid digit restarts the idle timer
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    cyc(0, 0, 0, 1, 4'd4, 0, 0);
    cyc(0, 0, 0, 1, 4'd7, 0, 0);
    cyc(0, 0, 0, 1, 4'hA, 0, 0);
    n = 0;
    while (n < 1100) begin
      idle(0);
      n++;
      if (to) break;
    end
    chk64("to_idle_cycles", 64'(n), 64'd1000);
    chk8("to_pulse", outv, TO, M_ALL);
    chk64("to_balance", balance, 64'd4500);
    idle(0); chk8("to_deassert", outv, 8'h00, M_ALL);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    cyc(0, 0, 0, 1, 4'd4, 0, 0);
    cyc(0, 0, 0, 1, 4'd7, 0, 0);
    cyc(0, 0, 0, 1, 4'hA, 0, 0);
    cyc(0, 0, 0, 1, 4'd5, 0, 0);
    cyc(0, 0, 0, 1, 4'd6, 0, 0);
    idle(0);
    cyc(0, 0, 0, 0, 4'd0, 1, 32'd10);
    chk8("bad_digit_ignored", outv, BA, M_ALL);
    chk64("bad_digit_balance", balance, 64'd4510);

    // Amount strobe on the expiry cycle wins over the timeout
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h4756);
    idle(0);
    tos = 0;
    for (int k = 0; k < 999; k++) begin
      idle(0);
      if (to) tos++;
    end
    chk64("expiry_no_early_timeout", 64'(tos), 64'd0);
    cyc(0, 0, 0, 0, 4'd0, 1, 32'd5);
    chk8("expiry_strobe_wins", outv, BA, M_ALL);
    chk64("expiry_balance", balance, 64'd4515);

    // Saturating deposit on the 16-bit balance instance
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    chk64("sat_reset_balance", 64'(balance16), 64'd65000);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    pin(16'h4756);
    idle(0);
    cyc(0, 0, 0, 0, 4'd0, 1, 32'd1000);
    chk8("sat_pulse", outv16, BA, M_ALL);
    chk64("sat_balance", 64'(balance16), 64'd65535);
    idle(0);
    chk8("sat_deassert", outv16, 8'h00, M_ALL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
